// File: rtl/pe_scheduler.sv
// Scheduler for one 1-D convolution processing element: loads the filter and
// ifmap scratchpads, sequences the MAC over every window and hands off each partial sum.
module pe_scheduler #(
  parameter int FILT_LEN  = 4,
  parameter int IFMAP_LEN = 16,
  parameter int STRIDE    = 1,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              filt_done,
  input  logic              if_done,
  input  logic              psum_ready,
  output logic              filt_start,
  output logic              if_start,
  output logic              mac_en,
  output logic              acc_clr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic [ADDR_W-1:0] if_addr,
  output logic              psum_valid,
  output logic              busy,
  output logic              done
);

  localparam int NUM_WIN = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int CW      = ADDR_W + 1;
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
  localparam logic [CW-1:0] K_LAST   = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] W_LAST   = CW'(NUM_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_F  = 3'd1,
    S_LOAD_I  = 3'd2,
    S_COMPUTE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] w_q, w_d;
  logic [CW-1:0] k_q, k_d;
  logic          first_q, first_d;
  logic [CW-1:0] k_eff;
  logic [CW-1:0] if_addr_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      k_q     <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      first_q <= first_d;
    end
  end

  // psum handshake: psum_valid stays high in EMIT until a cycle with
  // psum_ready=1; the transfer happens on that rising edge.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_F;
          w_d     = '0;
          k_d     = '0;
        end
      end
      S_LOAD_F: begin
        if (filt_done) state_d = S_LOAD_I;
      end
      S_LOAD_I: begin
        if (if_done) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_EMIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (psum_ready) begin
          if (w_q == W_LAST) begin
            state_d = S_DONE;
          end else begin
            w_d     = w_q + 1'b1;
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    first_d = (state_d != state_q);
  end

  // In EMIT k has already wrapped, so the last tap index is used to hold addresses.
  always_comb begin
    filt_start   = 1'b0;
    if_start     = 1'b0;
    mac_en       = 1'b0;
    acc_clr      = 1'b0;
    filt_addr    = '0;
    if_addr      = '0;
    psum_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    k_eff        = (state_q == S_EMIT) ? K_LAST : k_q;
    if_addr_full = w_q * STRIDE_C + k_eff;
    unique case (state_q)
      S_LOAD_F: begin
        busy       = 1'b1;
        filt_start = first_q;
      end
      S_LOAD_I: begin
        busy     = 1'b1;
        if_start = first_q;
      end
      S_COMPUTE: begin
        busy      = 1'b1;
        mac_en    = 1'b1;
        acc_clr   = (k_q == '0);
        filt_addr = k_eff[ADDR_W-1:0];
        if_addr   = if_addr_full[ADDR_W-1:0];
      end
      S_EMIT: begin
        busy       = 1'b1;
        psum_valid = 1'b1;
        filt_addr  = k_eff[ADDR_W-1:0];
        if_addr    = if_addr_full[ADDR_W-1:0];
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
